// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the staged reset-release sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_RELEASE   = 3'd1,
    S_RUN       = 3'd2,
    S_SW_ASSERT = 3'd3,
    S_SW_ACK    = 3'd4
  } state_e;

  localparam int LOCK_CNT_MAX = 255;

  // Width of the shared delay/filter/hold counter: large enough to hold the biggest terminal count.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for a single asynchronous level input.
module sync_ff_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[DEPTH-2:0], d};
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Releases NUM_STAGES downstream reset domains in order once the PLL lock is stable,
// re-asserting them on lock loss or on a software reset handshake.
module reset_release_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DLY   = 16,
  parameter int SYNC_DEPTH  = 2,
  parameter int LOCK_FILTER = 8,
  parameter int HOLD_CYC    = 32
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  PLL_LOCK,
  input  logic                  SW_RST_REQ,
  output logic                  SW_RST_ACK,
  output logic [NUM_STAGES-1:0] STAGE_RESETN,
  output logic                  ALL_READY,
  output logic [7:0]            LOCK_LOSS_CNT,
  output logic [2:0]            STATE
);

  localparam int CW = cnt_width(STAGE_DLY, LOCK_FILTER, HOLD_CYC);
  localparam int IW = $clog2(NUM_STAGES) + 1;

  logic lock_s, req_s, lock_prev;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic ready_q, ready_d, ack_q, ack_d, loss_inc;
  logic [7:0] loss_cnt_q;

  sync_ff_chain #(.DEPTH(SYNC_DEPTH)) u_sync_lock (
    .clk(CLK), .rst_n(RESETN), .d(PLL_LOCK), .q(lock_s)
  );

  sync_ff_chain #(.DEPTH(SYNC_DEPTH)) u_sync_req (
    .clk(CLK), .rst_n(RESETN), .d(SW_RST_REQ), .q(req_s)
  );

  // cnt_q is the lock filter in HOLD, the stage spacing timer in RELEASE and the hold timer in SW_ASSERT.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    stage_d  = stage_q;
    ready_d  = ready_q;
    ack_d    = ack_q;
    loss_inc = 1'b0;
    case (state_q)
      S_HOLD: begin
        stage_d = '0;
        ready_d = 1'b0;
        ack_d   = 1'b0;
        idx_d   = '0;
        if (cnt_q == CW'(LOCK_FILTER)) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else if (lock_s) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      S_RELEASE, S_RUN: begin
        if (!lock_s) begin
          state_d  = S_HOLD;
          cnt_d    = '0;
          stage_d  = '0;
          ready_d  = 1'b0;
          loss_inc = 1'b1;
        end else if (req_s) begin
          state_d = S_SW_ASSERT;
          cnt_d   = '0;
          stage_d = '0;
          ready_d = 1'b0;
        end else if (state_q == S_RUN) begin
          ready_d = 1'b1;
        end else if (cnt_q == CW'(STAGE_DLY - 1)) begin
          cnt_d   = '0;
          stage_d = stage_q | (NUM_STAGES'(1) << idx_q);
          idx_d   = idx_q + IW'(1);
          if (idx_q == IW'(NUM_STAGES - 1)) state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SW_ASSERT: begin
        // Only a falling edge counts here, since lock loss does not end this state.
        loss_inc = lock_prev & ~lock_s;
        if (cnt_q == CW'(HOLD_CYC - 1)) begin
          state_d = S_SW_ACK;
          cnt_d   = '0;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SW_ACK: begin
        loss_inc = lock_prev & ~lock_s;
        if (!req_s) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
        idx_d   = '0;
        stage_d = '0;
        ready_d = 1'b0;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      idx_q      <= '0;
      stage_q    <= '0;
      ready_q    <= 1'b0;
      ack_q      <= 1'b0;
      lock_prev  <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      stage_q   <= stage_d;
      ready_q   <= ready_d;
      ack_q     <= ack_d;
      lock_prev <= lock_s;
      if (loss_inc && (loss_cnt_q != 8'(LOCK_CNT_MAX))) loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign STAGE_RESETN  = stage_q;
  assign ALL_READY     = ready_q;
  assign SW_RST_ACK    = ack_q;
  assign LOCK_LOSS_CNT = loss_cnt_q;
  assign STATE         = state_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Randomised and directed bench for reset_release_sequencer against a behavioural reference model.
module tb_reset_release_sequencer;

  localparam int N   = 4;
  localparam int DLY = 16;
  localparam int SD  = 2;
  localparam int LF  = 8;
  localparam int HC  = 32;

  localparam int M_HOLD = 0, M_REL = 1, M_RUN = 2, M_SWH = 3, M_SWA = 4;

  logic         CLK = 1'b0;
  logic         RESETN, PLL_LOCK, SW_RST_REQ;
  logic         SW_RST_ACK, ALL_READY;
  logic [N-1:0] STAGE_RESETN;
  logic [7:0]   LOCK_LOSS_CNT;
  logic [2:0]   STATE;

  always #5 CLK = ~CLK;

  reset_release_sequencer #(
    .NUM_STAGES(N), .STAGE_DLY(DLY), .SYNC_DEPTH(SD), .LOCK_FILTER(LF), .HOLD_CYC(HC)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .PLL_LOCK(PLL_LOCK), .SW_RST_REQ(SW_RST_REQ),
    .SW_RST_ACK(SW_RST_ACK), .STAGE_RESETN(STAGE_RESETN), .ALL_READY(ALL_READY),
    .LOCK_LOSS_CNT(LOCK_LOSS_CNT), .STATE(STATE)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: delayed copies of the inputs plus spec-level bookkeeping.
  int m_mode, m_run, m_elapsed, m_held, m_loss;
  bit m_ready, m_ack, m_lsprev;
  bit lk_hist[SD];
  bit rq_hist[SD];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_HOLD; m_run = 0; m_elapsed = 0; m_held = 0; m_loss = 0;
    m_ready = 0; m_ack = 0; m_lsprev = 0;
    for (int i = 0; i < SD; i++) begin
      lk_hist[i] = 0;
      rq_hist[i] = 0;
    end
  endtask

  function automatic int exp_stage();
    int r;
    if (m_mode == M_RUN) return (1 << N) - 1;
    if (m_mode == M_REL) begin
      r = m_elapsed / DLY;
      if (r > N) r = N;
      return (1 << r) - 1;
    end
    return 0;
  endfunction

  task automatic bump_loss();
    if (m_loss < 255) m_loss++;
  endtask

  task automatic model_step();
    bit ls, rs;
    if (!RESETN) begin
      model_reset();
      return;
    end
    ls = lk_hist[SD-1];
    rs = rq_hist[SD-1];
    for (int i = SD - 1; i > 0; i--) begin
      lk_hist[i] = lk_hist[i-1];
      rq_hist[i] = rq_hist[i-1];
    end
    lk_hist[0] = PLL_LOCK;
    rq_hist[0] = SW_RST_REQ;
    case (m_mode)
      M_HOLD: begin
        m_ready = 0; m_ack = 0;
        if (m_run == LF) begin
          m_mode = M_REL; m_elapsed = 0;
        end else begin
          m_run = ls ? m_run + 1 : 0;
        end
      end
      M_REL, M_RUN: begin
        if (!ls) begin
          m_mode = M_HOLD; m_run = 0; m_ready = 0; bump_loss();
        end else if (rs) begin
          m_mode = M_SWH; m_held = 0; m_ready = 0;
        end else if (m_mode == M_REL) begin
          m_elapsed++;
          if (m_elapsed == N * DLY) m_mode = M_RUN;
        end else begin
          m_ready = 1;
        end
      end
      M_SWH: begin
        if (m_lsprev && !ls) bump_loss();
        m_held++;
        if (m_held == HC) begin
          m_mode = M_SWA; m_ack = 1;
        end
      end
      default: begin
        if (m_lsprev && !ls) bump_loss();
        if (!rs) begin
          m_mode = M_HOLD; m_ack = 0; m_run = 0;
        end
      end
    endcase
    m_lsprev = ls;
  endtask

  task automatic compare_all();
    check("stage", 32'(STAGE_RESETN), 32'(exp_stage()));
    check("state", 32'(STATE), 32'(m_mode));
    check("ready", 32'(ALL_READY), 32'(m_ready));
    check("ack", 32'(SW_RST_ACK), 32'(m_ack));
    check("loss_cnt", 32'(LOCK_LOSS_CNT), 32'(m_loss));
  endtask

  task automatic tick();
    @(posedge CLK);
    cyc++;
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (ALL_READY !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    check(tag, 32'(ALL_READY), 32'd1);
  endtask

  initial begin
    int base, loss0, k, prev_state;
    RESETN = 1'b0; PLL_LOCK = 1'b0; SW_RST_REQ = 1'b0;
    model_reset();
    #1;
    check("reset_stage", 32'(STAGE_RESETN), 32'd0);
    check("reset_state", 32'(STATE), 32'd0);
    run(5);
    RESETN = 1'b1;

    // Power-up: lock present before edge 10.
    while (cyc < 90) begin
      tick();
      if (cyc == 9) PLL_LOCK = 1'b1;
      case (cyc)
        19: check("pu_state19", 32'(STATE), 32'd0);
        20: check("pu_state20", 32'(STATE), 32'd1);
        35: check("pu_stage35", 32'(STAGE_RESETN), 32'h0);
        36: check("pu_stage36", 32'(STAGE_RESETN), 32'h1);
        52: check("pu_stage52", 32'(STAGE_RESETN), 32'h3);
        68: check("pu_stage68", 32'(STAGE_RESETN), 32'h7);
        84: begin
          check("pu_stage84", 32'(STAGE_RESETN), 32'hF);
          check("pu_ready84", 32'(ALL_READY), 32'd0);
        end
        85: check("pu_ready85", 32'(ALL_READY), 32'd1);
        default: ;
      endcase
    end

    // Lock loss in RUN for 3 cycles.
    loss0 = m_loss;
    PLL_LOCK = 1'b0;
    run(2);
    check("ll_stage_p2", 32'(STAGE_RESETN), 32'hF);
    tick();
    check("ll_stage_p3", 32'(STAGE_RESETN), 32'h0);
    check("ll_ready_p3", 32'(ALL_READY), 32'd0);
    check("ll_cnt_p3", 32'(LOCK_LOSS_CNT), 32'(loss0 + 1));
    PLL_LOCK = 1'b1;
    wait_ready("ll_rerelease");

    // Lock glitch in HOLD: 5 high, low, then stable.
    PLL_LOCK = 1'b0;
    run(10);
    PLL_LOCK = 1'b1;
    run(5);
    PLL_LOCK = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("gl_no_release", 32'(STAGE_RESETN), 32'h0);
    end
    PLL_LOCK = 1'b1;
    base = cyc;
    run(10);
    check("gl_state_p10", 32'(STATE), 32'd0);
    tick();
    check("gl_state_p11", 32'(STATE), 32'd1);
    wait_ready("gl_ready");

    // Software reset held 100 cycles.
    loss0 = m_loss;
    SW_RST_REQ = 1'b1;
    base = cyc;
    while (cyc < base + 100) begin
      tick();
      if (cyc == base + 2) check("sw_stage_p2", 32'(STAGE_RESETN), 32'hF);
      if (cyc == base + 3) begin
        check("sw_stage_p3", 32'(STAGE_RESETN), 32'h0);
        check("sw_state_p3", 32'(STATE), 32'd3);
      end
      if (cyc == base + 34) check("sw_ack_p34", 32'(SW_RST_ACK), 32'd0);
      if (cyc == base + 35) check("sw_ack_p35", 32'(SW_RST_ACK), 32'd1);
    end
    check("sw_ack_held", 32'(SW_RST_ACK), 32'd1);
    SW_RST_REQ = 1'b0;
    run(3);
    check("sw_ack_drop", 32'(SW_RST_ACK), 32'd0);
    wait_ready("sw_rerelease");
    check("sw_loss_same", 32'(LOCK_LOSS_CNT), 32'(loss0));

    // Simultaneous request and lock loss.
    loss0 = m_loss;
    SW_RST_REQ = 1'b1;
    PLL_LOCK = 1'b0;
    run(3);
    check("sim_state", 32'(STATE), 32'd0);
    check("sim_cnt", 32'(LOCK_LOSS_CNT), 32'(loss0 + 1));
    PLL_LOCK = 1'b1;
    k = 0;
    prev_state = STATE;
    while (STATE !== 3'd3 && k < 100) begin
      prev_state = STATE;
      tick();
      k++;
    end
    check("sim_sw_taken", 32'(STATE), 32'd3);
    check("sim_from_release", 32'(prev_state), 32'd1);
    SW_RST_REQ = 1'b0;
    wait_ready("sim_rerelease");

    // Randomised episodes.
    for (int ep = 0; ep < 30; ep++) begin
      run($urandom_range(0, 40));
      case ($urandom_range(0, 3))
        0: begin
          PLL_LOCK = 1'b0;
          run($urandom_range(1, 6));
          PLL_LOCK = 1'b1;
        end
        1: begin
          SW_RST_REQ = 1'b1;
          run($urandom_range(1, 80));
          SW_RST_REQ = 1'b0;
        end
        2: begin
          SW_RST_REQ = 1'b1;
          PLL_LOCK = 1'b0;
          run($urandom_range(1, 6));
          PLL_LOCK = 1'b1;
          run($urandom_range(1, 60));
          SW_RST_REQ = 1'b0;
        end
        default: begin
          PLL_LOCK = 1'b0;
          run($urandom_range(1, 2));
          PLL_LOCK = 1'b1;
          run($urandom_range(1, 4));
          PLL_LOCK = 1'b0;
          run(1);
          PLL_LOCK = 1'b1;
        end
      endcase
      run($urandom_range(60, 120));
    end

    // Mid-operation reset with two stages released.
    wait_ready("mr_ready");
    PLL_LOCK = 1'b0;
    run(3);
    PLL_LOCK = 1'b1;
    k = 0;
    while (STAGE_RESETN !== 4'h3 && k < 200) begin
      tick();
      k++;
    end
    check("mr_two_stages", 32'(STAGE_RESETN), 32'h3);
    RESETN = 1'b0;
    #1;
    check("mr_stage", 32'(STAGE_RESETN), 32'h0);
    check("mr_state", 32'(STATE), 32'd0);
    check("mr_ready", 32'(ALL_READY), 32'd0);
    check("mr_ack", 32'(SW_RST_ACK), 32'd0);
    check("mr_cnt", 32'(LOCK_LOSS_CNT), 32'd0);
    model_reset();
    run(3);
    RESETN = 1'b1;

    // Saturation of the lock-loss counter.
    for (int ev = 0; ev < 300; ev++) begin
      k = 0;
      while (STATE !== 3'd1 && STATE !== 3'd2 && k < 60) begin
        tick();
        k++;
      end
      if (k >= 60) check("sat_wait_release", 32'(STATE), 32'd1);
      PLL_LOCK = 1'b0;
      run(3);
      PLL_LOCK = 1'b1;
    end
    run(5);
    check("sat_cnt", 32'(LOCK_LOSS_CNT), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
